// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected tile scheduler.
package fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } fc_sched_state_t;

    localparam int unsigned FC_TILE_F = 32'd4;
    localparam int unsigned FC_TILE_O = 32'd2;

    // Integer ceiling division; den is always a non-zero tile constant here.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/fc_tile_iter.sv
// Walks the tile space of one layer: row outer, output tile middle, feature tile inner,
// and reports per-op payload fields plus the final-op flag.
module fc_tile_iter
    import fc_pkg::*;
#(
    parameter int unsigned TILE_F = FC_TILE_F,
    parameter int unsigned TILE_O = FC_TILE_O,
    parameter int unsigned DIM_W  = 32'd16,
    localparam int unsigned FCNT_W = $clog2(TILE_F + 32'd1),
    localparam int unsigned OCNT_W = $clog2(TILE_O + 32'd1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DIM_W-1:0]  batch,
    input  logic [DIM_W-1:0]  feat,
    input  logic [DIM_W-1:0]  outs,
    output logic [DIM_W-1:0]  row,
    output logic [DIM_W-1:0]  ftile,
    output logic [DIM_W-1:0]  otile,
    output logic [FCNT_W-1:0] fcnt,
    output logic [OCNT_W-1:0] ocnt,
    output logic              first,
    output logic              last,
    output logic              final_op
);

    localparam logic [DIM_W-1:0] ONE_D = {{(DIM_W-1){1'b0}}, 1'b1};

    logic [DIM_W-1:0]  row_r, ftile_r, otile_r, nb_r, nf_r, no_r;
    logic [FCNT_W-1:0] frem_r, frem_s;
    logic [OCNT_W-1:0] orem_r, orem_s;
    logic [DIM_W-1:0]  nf_s, no_s;
    logic              f_last_s, o_last_s, r_last_s;

    // Tile counts and ragged-edge widths of the layer being loaded
    always_comb begin
        nf_s   = DIM_W'(ceil_div(32'(feat), TILE_F));
        no_s   = DIM_W'(ceil_div(32'(outs), TILE_O));
        frem_s = FCNT_W'(32'(feat) - (32'(nf_s) - 32'd1) * TILE_F);
        orem_s = OCNT_W'(32'(outs) - (32'(no_s) - 32'd1) * TILE_O);
    end

    // Position flags derived from the current indices
    always_comb begin
        f_last_s = (ftile_r == nf_r - ONE_D);
        o_last_s = (otile_r == no_r - ONE_D);
        r_last_s = (row_r == nb_r - ONE_D);
    end

    assign row      = row_r;
    assign ftile    = ftile_r;
    assign otile    = otile_r;
    assign fcnt     = f_last_s ? frem_r : FCNT_W'(TILE_F);
    assign ocnt     = o_last_s ? orem_r : OCNT_W'(TILE_O);
    assign first    = (ftile_r == {DIM_W{1'b0}});
    assign last     = f_last_s;
    assign final_op = f_last_s & o_last_s & r_last_s;

    // Nested index counters; the walk stops at the final op so no index ever wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r   <= {DIM_W{1'b0}};
            ftile_r <= {DIM_W{1'b0}};
            otile_r <= {DIM_W{1'b0}};
            nb_r    <= {DIM_W{1'b0}};
            nf_r    <= {DIM_W{1'b0}};
            no_r    <= {DIM_W{1'b0}};
            frem_r  <= {FCNT_W{1'b0}};
            orem_r  <= {OCNT_W{1'b0}};
        end else if (load) begin
            nb_r    <= batch;
            nf_r    <= nf_s;
            no_r    <= no_s;
            frem_r  <= frem_s;
            orem_r  <= orem_s;
            row_r   <= {DIM_W{1'b0}};
            ftile_r <= {DIM_W{1'b0}};
            otile_r <= {DIM_W{1'b0}};
        end else if (advance) begin
            if (f_last_s) begin
                ftile_r <= {DIM_W{1'b0}};
                if (o_last_s) begin
                    otile_r <= {DIM_W{1'b0}};
                    row_r   <= row_r + ONE_D;
                end else begin
                    otile_r <= otile_r + ONE_D;
                end
            end else begin
                ftile_r <= ftile_r + ONE_D;
            end
        end
    end

endmodule

// File: rtl/fc_tile_scheduler.sv
// Accepts one fully-connected layer command and issues its tile ops to the MAC engine,
// bounding outstanding ops and reporting completion, abort and malformed commands.
module fc_tile_scheduler
    import fc_pkg::*;
#(
    parameter int unsigned TILE_F       = FC_TILE_F,
    parameter int unsigned TILE_O       = FC_TILE_O,
    parameter int unsigned DIM_W        = 32'd16,
    parameter int unsigned MAX_INFLIGHT = 32'd2,
    localparam int unsigned FCNT_W = $clog2(TILE_F + 32'd1),
    localparam int unsigned OCNT_W = $clog2(TILE_O + 32'd1),
    localparam int unsigned INF_W  = $clog2(MAX_INFLIGHT + 32'd1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DIM_W-1:0]  cmd_batch,
    input  logic [DIM_W-1:0]  cmd_feat,
    input  logic [DIM_W-1:0]  cmd_out,
    input  logic              abort,
    output logic              eng_valid,
    input  logic              eng_ready,
    output logic [DIM_W-1:0]  eng_row,
    output logic [DIM_W-1:0]  eng_ftile,
    output logic [DIM_W-1:0]  eng_otile,
    output logic [FCNT_W-1:0] eng_fcnt,
    output logic [OCNT_W-1:0] eng_ocnt,
    output logic              eng_first,
    output logic              eng_last,
    input  logic              eng_ack,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    localparam logic [INF_W-1:0] INF_ONE = {{(INF_W-1){1'b0}}, 1'b1};

    fc_sched_state_t  state_r, state_nxt_s;
    logic [DIM_W-1:0] batch_r, feat_r, out_r;
    logic [INF_W-1:0] inflight_r, inflight_nxt_s;
    logic             eng_valid_r, eng_valid_nxt_s;
    logic             done_r, done_nxt_s, aborted_r, aborted_nxt_s, err_r, err_nxt_s;
    logic             abort_seen_r, abort_seen_nxt_s;
    logic             latch_s, load_s, xfer_s, ack_s, inf_ok_s, final_s;

    fc_tile_iter #(
        .TILE_F (TILE_F),
        .TILE_O (TILE_O),
        .DIM_W  (DIM_W)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .advance  (xfer_s),
        .batch    (batch_r),
        .feat     (feat_r),
        .outs     (out_r),
        .row      (eng_row),
        .ftile    (eng_ftile),
        .otile    (eng_otile),
        .fcnt     (eng_fcnt),
        .ocnt     (eng_ocnt),
        .first    (eng_first),
        .last     (eng_last),
        .final_op (final_s)
    );

    // Engine handshake and outstanding-op accounting; acks with nothing outstanding are dropped
    always_comb begin
        xfer_s = eng_valid_r & eng_ready;
        ack_s  = eng_ack & (inflight_r != {INF_W{1'b0}});
        case ({xfer_s, ack_s})
            2'b10:   inflight_nxt_s = inflight_r + INF_ONE;
            2'b01:   inflight_nxt_s = inflight_r - INF_ONE;
            default: inflight_nxt_s = inflight_r;
        endcase
        inf_ok_s = (32'(inflight_nxt_s) < MAX_INFLIGHT);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt_s      = state_r;
        eng_valid_nxt_s  = eng_valid_r;
        done_nxt_s       = 1'b0;
        aborted_nxt_s    = 1'b0;
        err_nxt_s        = 1'b0;
        abort_seen_nxt_s = abort_seen_r;
        latch_s          = 1'b0;
        load_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                eng_valid_nxt_s = 1'b0;
                if (cmd_valid) begin
                    latch_s          = 1'b1;
                    abort_seen_nxt_s = 1'b0;
                    if ((cmd_batch == {DIM_W{1'b0}}) || (cmd_feat == {DIM_W{1'b0}}) ||
                        (cmd_out == {DIM_W{1'b0}})) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                load_s = 1'b1;
                if (abort) begin
                    abort_seen_nxt_s = 1'b1;
                    eng_valid_nxt_s  = 1'b0;
                    state_nxt_s      = ST_DRAIN;
                end else begin
                    eng_valid_nxt_s  = inf_ok_s;
                    state_nxt_s      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    abort_seen_nxt_s = 1'b1;
                    eng_valid_nxt_s  = 1'b0;
                    state_nxt_s      = ST_DRAIN;
                end else if (xfer_s && final_s) begin
                    eng_valid_nxt_s  = 1'b0;
                    state_nxt_s      = ST_DRAIN;
                end else if (eng_valid_r && !eng_ready) begin
                    // An offered op stays put until the engine takes it
                    eng_valid_nxt_s  = 1'b1;
                end else begin
                    eng_valid_nxt_s  = inf_ok_s;
                end
            end
            ST_DRAIN: begin
                eng_valid_nxt_s = 1'b0;
                if (inflight_r == {INF_W{1'b0}}) begin
                    done_nxt_s    = 1'b1;
                    aborted_nxt_s = abort_seen_r;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s   = ST_DRAIN;
                end
            end
            default: begin
                eng_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State, counters, command fields and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            inflight_r   <= {INF_W{1'b0}};
            eng_valid_r  <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            err_r        <= 1'b0;
            abort_seen_r <= 1'b0;
            batch_r      <= {DIM_W{1'b0}};
            feat_r       <= {DIM_W{1'b0}};
            out_r        <= {DIM_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            inflight_r   <= inflight_nxt_s;
            eng_valid_r  <= eng_valid_nxt_s;
            done_r       <= done_nxt_s;
            aborted_r    <= aborted_nxt_s;
            err_r        <= err_nxt_s;
            abort_seen_r <= abort_seen_nxt_s;
            if (latch_s) begin
                batch_r <= cmd_batch;
                feat_r  <= cmd_feat;
                out_r   <= cmd_out;
            end
        end
    end

    assign cmd_ready = (state_r == ST_IDLE) & ~rst;
    assign busy      = (state_r != ST_IDLE);
    assign eng_valid = eng_valid_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign err       = err_r;

endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Randomized bench for fc_tile_scheduler: a queue of expected tile ops built from the layer
// dimensions, plus a small engine model that tracks outstanding ops independently.
module tb_fc_tile_scheduler;

    localparam int TF = 4;
    localparam int TO = 2;
    localparam int DW = 16;
    localparam int MI = 2;
    localparam int FW = $clog2(TF + 1);
    localparam int OW = $clog2(TO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_batch = '0, cmd_feat = '0, cmd_out = '0;
    logic          abort = 1'b0;
    logic          eng_valid;
    logic          eng_ready = 1'b0;
    logic [DW-1:0] eng_row, eng_ftile, eng_otile;
    logic [FW-1:0] eng_fcnt;
    logic [OW-1:0] eng_ocnt;
    logic          eng_first, eng_last;
    logic          eng_ack = 1'b0;
    logic          busy, done, aborted, err;

    always #5 clk = ~clk;

    fc_tile_scheduler #(
        .TILE_F(TF), .TILE_O(TO), .DIM_W(DW), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_batch(cmd_batch), .cmd_feat(cmd_feat), .cmd_out(cmd_out), .abort(abort),
        .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_row(eng_row), .eng_ftile(eng_ftile),
        .eng_otile(eng_otile), .eng_fcnt(eng_fcnt), .eng_ocnt(eng_ocnt), .eng_first(eng_first),
        .eng_last(eng_last), .eng_ack(eng_ack), .busy(busy), .done(done), .aborted(aborted),
        .err(err)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    int          outstanding = 0;
    logic [63:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [63:0] pack(input int r, input int ft, input int ot, input int fc,
                                         input int oc, input int fi, input int la);
        return {9'd0, DW'(r), DW'(ft), DW'(ot), FW'(fc), OW'(oc), fi[0], la[0]};
    endfunction

    function automatic logic [63:0] dut_payload();
        return pack(int'(eng_row), int'(eng_ftile), int'(eng_otile), int'(eng_fcnt),
                    int'(eng_ocnt), int'(eng_first), int'(eng_last));
    endfunction

    task automatic issue_cmd(input int b, input int f, input int o);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_batch = DW'(b);
        cmd_feat  = DW'(f);
        cmd_out   = DW'(o);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // abort_at < 0: no abort; stall: ready forced low for the first cycles valid is seen;
    // hold_acks: no acks before that cycle of the issue loop
    task automatic run_layer(input int b, input int f, input int o, input int rdy_pct,
                             input int ack_pct, input int abort_at, input int stall,
                             input int hold_acks);
        int nf, no, xfers, dones, cyc, seen_valid;
        bit abort_done, hold_chk;
        logic [63:0] held, pl;
        nf = (f + TF - 1) / TF;
        no = (o + TO - 1) / TO;
        exp_q.delete();
        for (int r = 0; r < b; r++)
            for (int ot = 0; ot < no; ot++)
                for (int ft = 0; ft < nf; ft++)
                    exp_q.push_back(pack(r, ft, ot, min_i(TF, f - ft * TF), min_i(TO, o - ot * TO),
                                         int'(ft == 0), int'(ft == nf - 1)));
        xfers = 0; dones = 0; cyc = 0; seen_valid = 0;
        abort_done = 1'b0; hold_chk = 1'b0; held = '0;
        outstanding = 0;
        issue_cmd(b, f, o);
        check_eq("setup_busy", 64'(busy), 64'd1);
        check_eq("setup_valid", 64'(eng_valid), 64'd0);
        while (cyc < 3000 && dones == 0) begin
            @(negedge clk);
            pl = dut_payload();
            if (cyc == 0) check_eq("first_valid", 64'(eng_valid), 64'd1);
            if (hold_chk) begin
                check_eq("hold_valid", 64'(eng_valid), 64'd1);
                check_eq("hold_payload", pl, held);
            end
            if (eng_valid) check_eq("inflight_cap", 64'(outstanding < MI), 64'd1);
            if (abort_done) check_eq("abort_drop", 64'(eng_valid), 64'd0);
            if (hold_acks > 0 && cyc == hold_acks) begin
                check_eq("held_ack_xfers", 64'(xfers), 64'(MI));
                check_eq("held_ack_valid", 64'(eng_valid), 64'd0);
            end
            check_eq("no_err", 64'(err), 64'd0);
            if (done) begin
                dones++;
                check_eq("done_after_acks", 64'(outstanding), 64'd0);
                check_eq("aborted_flag", 64'(aborted), 64'(abort_at >= 0));
                if (abort_at >= 0) check_eq("abort_op_count", 64'(xfers), 64'(abort_at));
                else check_eq("ops_left", 64'(exp_q.size()), 64'd0);
            end
            abort = 1'b0;
            if (abort_at >= 0 && !abort_done && xfers == abort_at && dones == 0) begin
                abort      = 1'b1;
                abort_done = 1'b1;
                eng_ready  = 1'b0;
            end else if (eng_valid && seen_valid < stall) begin
                eng_ready = 1'b0;
            end else begin
                eng_ready = ($urandom_range(99) < rdy_pct);
            end
            if (eng_valid) seen_valid++;
            eng_ack = (outstanding > 0 && cyc >= hold_acks && $urandom_range(99) < ack_pct);
            if (eng_valid && eng_ready) begin
                xfers++;
                outstanding++;
                if (exp_q.size() == 0) check_eq("extra_op", 64'(exp_q.size()), 64'd1);
                else check_eq("op_payload", pl, exp_q.pop_front());
                hold_chk = 1'b0;
            end else if (eng_valid && !abort) begin
                hold_chk = 1'b1;
                held     = pl;
            end else begin
                hold_chk = 1'b0;
            end
            if (eng_ack) outstanding--;
            cyc++;
        end
        check_eq("done_seen", 64'(dones), 64'd1);
        eng_ready = 1'b0;
        eng_ack   = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_err(input int b, input int f, input int o);
        issue_cmd(b, f, o);
        check_eq("err_pulse", 64'(err), 64'd1);
        check_eq("err_ready", 64'(cmd_ready), 64'd1);
        check_eq("err_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("err_once", 64'(err), 64'd0);
            check_eq("err_no_valid", 64'(eng_valid), 64'd0);
        end
    endtask

    initial begin
        int rb, rf, ro, tot, ab;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_valid", 64'(eng_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_aborted", 64'(aborted), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(cmd_ready), 64'd1);

        run_layer(1, 3, 2, 100, 100, -1, 0, 0);
        run_layer(2, 10, 5, 100, 100, -1, 0, 0);
        run_layer(1, 8, 2, 100, 50, -1, 5, 0);
        run_err(1, 0, 3);
        run_err(0, 4, 2);
        run_err(2, 5, 0);
        run_layer(2, 10, 5, 100, 60, 3, 0, 0);

        // Reset in the middle of issuing, then a stale ack that must be ignored
        issue_cmd(3, 9, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            eng_ready = 1'b1;
            eng_ack   = 1'b0;
        end
        @(negedge clk);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        eng_ready = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid", 64'(eng_valid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_ready", 64'(cmd_ready), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        eng_ack = 1'b1;
        @(negedge clk);
        eng_ack = 1'b0;
        check_eq("after_rst_ready", 64'(cmd_ready), 64'd1);
        run_layer(2, 5, 3, 100, 60, -1, 0, 8);

        for (int k = 0; k < 10; k++) begin
            rb  = $urandom_range(1, 3);
            rf  = $urandom_range(1, 13);
            ro  = $urandom_range(1, 5);
            tot = rb * ((rf + TF - 1) / TF) * ((ro + TO - 1) / TO);
            ab  = -1;
            if (tot > 1 && $urandom_range(3) == 0) ab = $urandom_range(1, tot - 1);
            run_layer(rb, rf, ro, $urandom_range(30, 100), $urandom_range(30, 100), ab, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
